// File: rtl/key_conditioner.sv
// key_conditioner: debounces four active-low push-buttons and qualifies the
// slide-switch clock divisor before they reach the clock interface.
module key_conditioner #(
    parameter int unsigned DEBOUNCE = 500000,
    parameter logic [7:0]  FDIV_RST = 8'd4
) (
    input  logic       iCLK_50,
    input  logic       iRST_n,
    input  logic [3:0] iKEY,
    input  logic [7:0] iSW,
    output logic [3:0] oKEY,
    output logic [3:0] oPress,
    output logic [3:0] oRelease,
    output logic [7:0] oFDIV,
    output logic       oFDIVUpd
);
    localparam int unsigned NKEY  = 4;
    localparam int unsigned SW_W  = 8;
    localparam int unsigned CNT_W = 20;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DEBOUNCE - 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        UP     = 2'd0,
        CHK_DN = 2'd1,
        DN     = 2'd2,
        CHK_UP = 2'd3
    } key_state_e;

    // Synchronizer stages
    logic [NKEY-1:0] key_meta_q, key_s_q;
    logic [SW_W-1:0] sw_meta_q, sw_s_q;

    // Key debouncers
    key_state_e      state_q [NKEY];
    key_state_e      state_d [NKEY];
    logic [CNT_W-1:0] cnt_q  [NKEY];
    logic [CNT_W-1:0] cnt_d  [NKEY];
    logic [NKEY-1:0] okey_q, okey_d;
    logic [NKEY-1:0] press_q, press_d;
    logic [NKEY-1:0] release_q, release_d;

    // Switch qualifier
    logic [SW_W-1:0]  last_q, last_d;
    logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;
    logic [SW_W-1:0]  fdiv_q, fdiv_d;
    logic             fdiv_upd_q, fdiv_upd_d;
    logic [SW_W-1:0]  fdiv_v;

    // Two-flop synchronizers; keys idle released, switches idle at the reset divisor
    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            key_meta_q <= '1;
            key_s_q    <= '1;
            sw_meta_q  <= FDIV_RST;
            sw_s_q     <= FDIV_RST;
        end else begin
            key_meta_q <= iKEY;
            key_s_q    <= key_meta_q;
            sw_meta_q  <= iSW;
            sw_s_q     <= sw_meta_q;
        end
    end

    // Per-key state, counter and registered outputs
    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            for (int unsigned k = 0; k < NKEY; k++) begin
                state_q[k] <= UP;
                cnt_q[k]   <= '0;
            end
            okey_q    <= '1;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            for (int unsigned k = 0; k < NKEY; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
            okey_q    <= okey_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Per-key debounce FSM: a new level must survive DEBOUNCE checks before it is accepted
    always_comb begin
        for (int unsigned k = 0; k < NKEY; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
        end
        okey_d    = okey_q;
        press_d   = '0;
        release_d = '0;
        for (int unsigned k = 0; k < NKEY; k++) begin
            unique case (state_q[k])
                UP: begin
                    if (!key_s_q[k]) begin
                        state_d[k] = CHK_DN;
                        cnt_d[k]   = '0;
                    end
                end
                CHK_DN: begin
                    if (key_s_q[k]) begin
                        state_d[k] = UP;
                        cnt_d[k]   = '0;
                    end else if (cnt_q[k] == CNT_LAST) begin
                        state_d[k] = DN;
                        cnt_d[k]   = '0;
                        okey_d[k]  = 1'b0;
                        press_d[k] = 1'b1;
                    end else begin
                        cnt_d[k] = cnt_q[k] + CNT_ONE;
                    end
                end
                DN: begin
                    if (key_s_q[k]) begin
                        state_d[k] = CHK_UP;
                        cnt_d[k]   = '0;
                    end
                end
                CHK_UP: begin
                    if (!key_s_q[k]) begin
                        state_d[k] = DN;
                        cnt_d[k]   = '0;
                    end else if (cnt_q[k] == CNT_LAST) begin
                        state_d[k]   = UP;
                        cnt_d[k]     = '0;
                        okey_d[k]    = 1'b1;
                        release_d[k] = 1'b1;
                    end else begin
                        cnt_d[k] = cnt_q[k] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[k] = UP;
                    cnt_d[k]   = '0;
                end
            endcase
        end
    end

    // Switch qualifier registers; divisor restarts at its nonzero reset value
    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            last_q     <= FDIV_RST;
            sw_cnt_q   <= '0;
            fdiv_q     <= FDIV_RST;
            fdiv_upd_q <= 1'b0;
        end else begin
            last_q     <= last_d;
            sw_cnt_q   <= sw_cnt_d;
            fdiv_q     <= fdiv_d;
            fdiv_upd_q <= fdiv_upd_d;
        end
    end

    // Publish the switch value once it has been stable; zero is promoted to 1
    always_comb begin
        last_d     = last_q;
        sw_cnt_d   = sw_cnt_q;
        fdiv_d     = fdiv_q;
        fdiv_upd_d = 1'b0;
        fdiv_v     = (last_q == '0) ? SW_W'(1) : last_q;
        if (sw_s_q != last_q) begin
            last_d   = sw_s_q;
            sw_cnt_d = '0;
        end else if (sw_cnt_q != CNT_LAST) begin
            sw_cnt_d = sw_cnt_q + CNT_ONE;
            if ((sw_cnt_q == CNT_PRE) && (fdiv_v != fdiv_q)) begin
                fdiv_d     = fdiv_v;
                fdiv_upd_d = 1'b1;
            end
        end
    end

    assign oKEY     = okey_q;
    assign oPress   = press_q;
    assign oRelease = release_q;
    assign oFDIV    = fdiv_q;
    assign oFDIVUpd = fdiv_upd_q;

endmodule
